// File: rtl/mul_booth_csa_pkg.sv
// Shared types and helpers for the radix-4 Booth carry-save multiplier.
// Holds the FSM state enum, the Booth digit encoding and the partial-product builder.
// The helpers work at the default datapath width; narrower instances zero-pad into them.
package mul_booth_csa_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_TAG_W = 5;
  localparam int PW        = 2 * DEF_XLEN;  // product / accumulator width
  localparam int SHW       = 8;             // enough bits for shifts up to PW-1

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    B_ZERO,
    B_POS1,
    B_POS2,
    B_NEG1,
    B_NEG2
  } booth_e;

  // Decode one overlapping multiplier window {b[2k+1], b[2k], b[2k-1]}.
  function automatic booth_e booth_digit(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: return B_POS1;
      3'b011:         return B_POS2;
      3'b100:         return B_NEG2;
      3'b101, 3'b110: return B_NEG1;
      default:        return B_ZERO;
    endcase
  endfunction

  // digit * A << shift, modulo 2^PW. Negation is a plain two's complement.
  function automatic logic [PW-1:0] booth_pp(input logic [PW-1:0] a, input booth_e d,
                                             input logic [SHW-1:0] sh);
    logic [PW-1:0] m;
    case (d)
      B_POS1:  m = a;
      B_POS2:  m = a << 1;
      B_NEG1:  m = -a;
      B_NEG2:  m = -(a << 1);
      default: m = '0;
    endcase
    return m << sh;
  endfunction

endpackage

// File: rtl/mul_booth_csa_if.sv
// Request/result bundle between the M-extension issue logic and the Booth front end.
// master = requester and downstream adder side; slave = the multiplier.
// flush travels with the bus because it is driven by the same pipeline control.
interface mul_booth_csa_if
  import mul_booth_csa_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_a;
  logic [XLEN-1:0]    in_b;
  logic               in_a_signed;
  logic               in_b_signed;
  logic               in_hi;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*XLEN-1:0]  out_sum;
  logic [2*XLEN-1:0]  out_carry;
  logic               out_hi;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, in_a, in_b, in_a_signed, in_b_signed, in_hi, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_hi, out_tag
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, in_a_signed, in_b_signed, in_hi, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_hi, out_tag
  );
endinterface

// File: rtl/mul_booth_csa_csa_3to2.sv
// Parameterised carry-save 3:2 compressor.
// Purely combinational: sum = x^y^z, carry = majority(x,y,z) shifted up one bit.
// The carry out of the top bit is dropped, so results are modulo 2^W.
module csa_3to2 #(
  parameter int W = 128
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  assign sum   = x ^ y ^ z;
  assign carry = ((x & y) | (x & z) | (y & z)) << 1;
endmodule

// File: rtl/mul_booth_csa.sv
// Iterative radix-4 Booth multiplier front end: one partial product per cycle into a sum/carry pair.
// Latency: out_valid rises exactly (XLEN+2)/2 cycles after acceptance; no early-out.
// Backpressure: the result is held in DONE until out_ready; requests are taken only in IDLE.
module mul_booth_csa
  import mul_booth_csa_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic           clk,
  input  logic           rst,
  mul_booth_csa_if.slave bus
);
  localparam int W     = 2 * XLEN;
  localparam int ITERS = (XLEN + 2) / 2;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     a_q;
  logic [XLEN+2:0]  b_q;     // {ext, ext, b, 1'b0}
  logic [W-1:0]     sum_q;
  logic [W-1:0]     carry_q;
  logic             hi_q;
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;
  logic             ready_q;

  logic             a_ext;
  logic             b_ext;
  logic [2:0]       win;
  booth_e           digit;
  logic [PW-1:0]    pp_full;
  logic [W-1:0]     pp;
  logic [W-1:0]     sum_n;
  logic [W-1:0]     carry_n;

  assign a_ext = bus.in_a_signed & bus.in_a[XLEN-1];
  assign b_ext = bus.in_b_signed & bus.in_b[XLEN-1];

  // Window for iteration k sits at bits [2k+2:2k] of the extended multiplier.
  assign win     = 3'(b_q >> {cnt, 1'b0});
  assign digit   = booth_digit(win);
  assign pp_full = booth_pp(PW'(a_q), digit, SHW'({cnt, 1'b0}));
  assign pp      = pp_full[W-1:0];

  csa_3to2 #(.W(W)) u_csa (
    .x     (sum_q),
    .y     (carry_q),
    .z     (pp),
    .sum   (sum_n),
    .carry (carry_n)
  );

  // Control FSM and datapath registers; flush overrides every state but keeps the old result bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      hi_q    <= 1'b0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (bus.flush) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state   <= BUSY;
            ready_q <= 1'b0;
            a_q     <= {{XLEN{a_ext}}, bus.in_a};
            b_q     <= {b_ext, b_ext, bus.in_b, 1'b0};
            sum_q   <= '0;
            carry_q <= '0;
            cnt     <= '0;
            hi_q    <= bus.in_hi;
            tag_q   <= bus.in_tag;
          end
        end
        BUSY: begin
          sum_q   <= sum_n;
          carry_q <= carry_n;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
  assign bus.out_hi    = hi_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_mul_booth_csa.sv
// Scoreboarded bench for mul_booth_csa: directed corner cases plus a randomized sweep.
// Expected products come from plain 128-bit arithmetic on the extended operands.
module tb_mul_booth_csa;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mul_booth_csa_if #(.XLEN(64), .TAG_W(5)) bif ();

  mul_booth_csa #(.XLEN(64), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic [127:0] prod;
    logic [4:0]   tag;
    logic         hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done_rand = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic as, input logic bs);
    logic signed [127:0] ea;
    logic signed [127:0] eb;
    ea = as ? {{64{a[63]}}, a} : {64'b0, a};
    eb = bs ? {{64{b[63]}}, b} : {64'b0, b};
    return 128'(ea * eb);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 9))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Present one request at a negedge once the block is ready; returns just after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs,
                       input logic hi, input logic [4:0] tag, input logic [127:0] prod,
                       input bit push);
    int w;
    w = 0;
    @(negedge clk);
    while (!bif.in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!bif.in_ready) timeout("issue_wait");
    bif.in_valid    = 1'b1;
    bif.in_a        = a;
    bif.in_b        = b;
    bif.in_a_signed = as;
    bif.in_b_signed = bs;
    bif.in_hi       = hi;
    bif.in_tag      = tag;
    @(posedge clk);
    if (push) exp_q.push_back('{prod, tag, hi});
    #1 bif.in_valid = 1'b0;
  endtask

  // Count edges from acceptance until out_valid, noting whether in_ready ever rose meanwhile.
  task automatic wait_valid(output int n, output bit rdy_low);
    n = 0;
    rdy_low = 1'b1;
    while (!bif.out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!bif.out_valid && bif.in_ready) rdy_low = 1'b0;
    end
    if (!bif.out_valid) timeout("wait_valid");
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: every accepted result is popped and compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bif.out_valid && bif.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got tag %h with nothing expected", bif.out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("product", bif.out_sum + bif.out_carry, e.prod);
        chk("tag", 128'(bif.out_tag), 128'(e.tag));
        chk1("hi", bif.out_hi, e.hi);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    bit          rl;
    logic [127:0] s_snap;
    logic [127:0] c_snap;
    logic [4:0]   t_snap;
    logic         h_snap;
    bit           saw;

    bif.flush       = 1'b0;
    bif.in_valid    = 1'b0;
    bif.in_a        = '0;
    bif.in_b        = '0;
    bif.in_a_signed = 1'b0;
    bif.in_b_signed = 1'b0;
    bif.in_hi       = 1'b0;
    bif.in_tag      = '0;
    bif.out_ready   = 1'b1;

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", bif.in_ready, 1'b1);
    chk1("rst_out_valid", bif.out_valid, 1'b0);
    chk("rst_out_sum", bif.out_sum, 128'h0);
    chk("rst_out_carry", bif.out_carry, 128'h0);
    chk("rst_out_tag", 128'(bif.out_tag), 128'h0);
    chk1("rst_out_hi", bif.out_hi, 1'b0);

    // 3 x 5 unsigned with exact latency.
    issue(64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 5'h03, 128'd15, 1'b1);
    wait_valid(n, rl);
    chk("latency_3x5", 128'(n), 128'(33));
    chk1("busy_in_ready_low", rl, 1'b1);
    drain();

    // Corner products.
    issue('1, '1, 1'b0, 1'b0, 1'b1, 5'h04,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1);
    issue('1, '1, 1'b1, 1'b1, 1'b0, 5'h05, 128'h1, 1'b1);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 5'h06,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b0, 1'b0, 5'h07,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 1'b1);
    drain();

    // Backpressure: result must hold and no request may slip in.
    @(posedge clk);
    #1 bif.out_ready = 1'b0;
    issue(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 1'b1, 5'h0B,
          ref_mul(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0), 1'b1);
    wait_valid(n, rl);
    chk("latency_bp", 128'(n), 128'(33));
    s_snap = bif.out_sum;
    c_snap = bif.out_carry;
    t_snap = bif.out_tag;
    h_snap = bif.out_hi;
    for (int i = 0; i < 10; i++) begin
      bif.in_valid = i[0];
      bif.in_a     = {$urandom, $urandom};
      bif.in_tag   = 5'(i);
      @(negedge clk);
      chk("bp_sum", bif.out_sum, s_snap);
      chk("bp_carry", bif.out_carry, c_snap);
      chk("bp_tag", 128'(bif.out_tag), 128'(t_snap));
      chk1("bp_hi", bif.out_hi, h_snap);
      chk1("bp_valid", bif.out_valid, 1'b1);
      chk1("bp_in_ready", bif.in_ready, 1'b0);
    end
    bif.in_valid = 1'b0;
    @(posedge clk);
    #1 bif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("bp_release_in_ready", bif.in_ready, 1'b1);
    chk1("bp_release_valid", bif.out_valid, 1'b0);
    drain();

    // Flush during iteration 10, then a flush racing a request in IDLE.
    issue(64'h0F0F_0F0F_0F0F_0F0F, 64'h3333_3333_3333_3333, 1'b0, 1'b0, 1'b0, 5'h1F, 128'h0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bif.flush = 1'b1;
    @(negedge clk);
    bif.flush = 1'b0;
    chk1("flush_in_ready", bif.in_ready, 1'b1);
    chk1("flush_out_valid", bif.out_valid, 1'b0);
    bif.flush    = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_a     = 64'd11;
    bif.in_b     = 64'd13;
    @(negedge clk);
    bif.flush    = 1'b0;
    bif.in_valid = 1'b0;
    chk1("flush_blocks_accept", bif.in_ready, 1'b1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bif.out_valid) saw = 1'b1;
    end
    chk1("flush_no_result", saw, 1'b0);
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFF7, 1'b1, 1'b1, 1'b0, 5'h15,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1, 1'b1);
    drain();

    // Asynchronous reset in the middle of an operation.
    issue(64'hDEAD_BEEF_0000_1111, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b1, 1'b1, 5'h1E, 128'h0, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk1("arst_out_valid", bif.out_valid, 1'b0);
    chk1("arst_in_ready", bif.in_ready, 1'b1);
    chk("arst_out_sum", bif.out_sum, 128'h0);
    chk("arst_out_carry", bif.out_carry, 128'h0);
    chk("arst_out_tag", 128'(bif.out_tag), 128'h0);
    chk1("arst_out_hi", bif.out_hi, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("arst_release_in_ready", bif.in_ready, 1'b1);
    chk1("arst_release_valid", bif.out_valid, 1'b0);

    // Randomized sweep with random downstream stalls.
    done_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 800; i++) begin
          logic [63:0] ra;
          logic [63:0] rb;
          logic        ras;
          logic        rbs;
          ra  = pick();
          rb  = pick();
          ras = 1'($urandom_range(0, 1));
          rbs = 1'($urandom_range(0, 1));
          issue(ra, rb, ras, rbs, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                ref_mul(ra, rb, ras, rbs), 1'b1);
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1 bif.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk);
    #1 bif.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
